// File: rtl/csr_trap_unit_if.sv
// Commit-side bus of the machine-mode CSR/trap unit: commit slot, interrupt
// lines, CSR access port and fetch redirect.
interface csr_trap_unit_if #(
  parameter int XLEN     = 32,
  parameter int NUM_LIRQ = 4
);
  logic [XLEN-1:0]     pc_i;
  logic                pc_valid_i;
  logic                instr_retire_i;
  logic                ext_irq_i;
  logic                sft_irq_i;
  logic                tmr_irq_i;
  logic [NUM_LIRQ-1:0] lirq_i;
  logic                exp_req_i;
  logic [4:0]          exp_cause_i;
  logic [XLEN-1:0]     exp_tval_i;
  logic                mret_i;
  logic                csr_rden_i;
  logic                csr_wen_i;
  logic [1:0]          csr_op_i;
  logic [11:0]         csr_addr_i;
  logic [XLEN-1:0]     csr_wdata_i;
  logic [XLEN-1:0]     csr_rdata_o;
  logic                csr_illegal_o;
  logic                redirect_o;
  logic [XLEN-1:0]     redirect_pc_o;
  logic                irq_pending_o;

  modport master (
    output pc_i, pc_valid_i, instr_retire_i, ext_irq_i, sft_irq_i, tmr_irq_i,
           lirq_i, exp_req_i, exp_cause_i, exp_tval_i, mret_i, csr_rden_i,
           csr_wen_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o, redirect_o, redirect_pc_o, irq_pending_o
  );

  modport slave (
    input  pc_i, pc_valid_i, instr_retire_i, ext_irq_i, sft_irq_i, tmr_irq_i,
           lirq_i, exp_req_i, exp_cause_i, exp_tval_i, mret_i, csr_rden_i,
           csr_wen_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o, redirect_o, redirect_pc_o, irq_pending_o
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller with fixed-priority interrupts and
// a one-cycle registered redirect. Define CSR_COUNTER_EN to add mcycle/minstret.
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_LIRQ    = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic           clk,
  input  logic           rst,
  csr_trap_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef CSR_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

  function automatic logic [XLEN-1:0] irq_mask_f();
    logic [XLEN-1:0] m;
    m     = '0;
    m[11] = 1'b1;
    m[7]  = 1'b1;
    m[3]  = 1'b1;
    for (int i = 0; i < NUM_LIRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] misa_f();
    logic [XLEN-1:0] m;
    m = '0;
    m[XLEN-1 -: 2] = (XLEN == 64) ? 2'b10 : 2'b01;
    m[8] = 1'b1;
    return m;
  endfunction

  localparam logic [XLEN-1:0] IRQ_MASK = irq_mask_f();
  localparam logic [XLEN-1:0] MISA_VAL = misa_f();

  typedef enum logic {IDLE, REDIR} state_t;

  state_t            state_reg, state_next;
  logic              mstatus_mie_reg, mstatus_mpie_reg;
  logic [XLEN-1:0]   mie_reg, mscratch_reg, mcause_reg, mtval_reg;
  logic [XLEN-3:0]   mtvec_base_reg, mepc_reg;
  logic              mtvec_mode_reg;
  logic [XLEN-1:0]   redirect_pc_reg;

  logic [XLEN-1:0]   mip_val, pend_en, rdata, wval, mtvec_base_addr, trap_target, trap_cause;
  logic [4:0]        irq_cause;
  logic              impl, read_only;
  logic              take_exc, take_irq, trap, take_mret, csr_we, mstatus_we;
`ifdef CSR_COUNTER_EN
  logic [63:0]       mcycle_reg, minstret_reg;
`endif

  always_comb begin
    mip_val     = '0;
    mip_val[11] = bus.ext_irq_i;
    mip_val[7]  = bus.tmr_irq_i;
    mip_val[3]  = bus.sft_irq_i;
    for (int i = 0; i < NUM_LIRQ; i++) mip_val[16+i] = bus.lirq_i[i];
  end

  assign pend_en           = mip_val & mie_reg;
  assign bus.irq_pending_o = |pend_en;

  // Later assignments override earlier ones, so the last check has top priority.
  always_comb begin
    irq_cause = '0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
      if (pend_en[16+i]) irq_cause = 5'(16 + i);
    end
    if (pend_en[7])  irq_cause = 5'd7;
    if (pend_en[3])  irq_cause = 5'd3;
    if (pend_en[11]) irq_cause = 5'd11;
  end

  assign take_exc  = (state_reg == IDLE) && bus.exp_req_i;
  assign take_irq  = (state_reg == IDLE) && !bus.exp_req_i && bus.pc_valid_i &&
                     mstatus_mie_reg && (pend_en != '0);
  assign trap      = take_exc || take_irq;
  assign take_mret = (state_reg == IDLE) && !trap && bus.mret_i;

  assign mtvec_base_addr = {mtvec_base_reg, 2'b00};
  assign trap_cause      = take_irq ? {1'b1, (XLEN-1)'(irq_cause)} : XLEN'(bus.exp_cause_i);
  assign trap_target     = (take_irq && mtvec_mode_reg) ?
                           mtvec_base_addr + (XLEN'(irq_cause) << 2) : mtvec_base_addr;

  always_comb begin
    rdata     = '0;
    impl      = 1'b1;
    read_only = 1'b0;
    case (bus.csr_addr_i)
      ADDR_MSTATUS: begin
        rdata[12:11] = 2'b11;
        rdata[7]     = mstatus_mpie_reg;
        rdata[3]     = mstatus_mie_reg;
      end
      ADDR_MISA:     begin rdata = MISA_VAL; read_only = 1'b1; end
      ADDR_MHARTID:  read_only = 1'b1;
      ADDR_MIE:      rdata = mie_reg;
      ADDR_MIP:      begin rdata = mip_val; read_only = 1'b1; end
      ADDR_MTVEC:    rdata = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
      ADDR_MSCRATCH: rdata = mscratch_reg;
      ADDR_MEPC:     rdata = {mepc_reg, 2'b00};
      ADDR_MCAUSE:   rdata = mcause_reg;
      ADDR_MTVAL:    rdata = mtval_reg;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE:   rdata = XLEN'(mcycle_reg);
      ADDR_MINSTRET: rdata = XLEN'(minstret_reg);
      ADDR_MCYCLEH:  if (XLEN == 32) rdata = XLEN'(mcycle_reg[63:32]); else impl = 1'b0;
      ADDR_MINSTRETH: if (XLEN == 32) rdata = XLEN'(minstret_reg[63:32]); else impl = 1'b0;
`endif
      default:       impl = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.csr_op_i)
      2'b10:   wval = rdata | bus.csr_wdata_i;
      2'b11:   wval = rdata & ~bus.csr_wdata_i;
      default: wval = bus.csr_wdata_i;
    endcase
  end

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = (bus.csr_rden_i || bus.csr_wen_i) &&
                             (!impl || (bus.csr_wen_i && read_only));

  // A trap squashes the write; MRET only blocks the mstatus write.
  assign csr_we     = bus.csr_wen_i && (bus.csr_op_i != 2'b00) && (state_reg == IDLE) &&
                      !trap && impl && !read_only;
  assign mstatus_we = csr_we && (bus.csr_addr_i == ADDR_MSTATUS) && !take_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_base_reg   <= RESET_MTVEC[XLEN-1:2];
      mtvec_mode_reg   <= (RESET_MTVEC[1:0] == 2'b01);
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      redirect_pc_reg  <= '0;
    end else begin
      if (mstatus_we) begin
        mstatus_mie_reg  <= wval[3];
        mstatus_mpie_reg <= wval[7];
      end
      if (csr_we) begin
        case (bus.csr_addr_i)
          ADDR_MIE:      mie_reg <= wval & IRQ_MASK;
          ADDR_MTVEC: begin
            mtvec_base_reg <= wval[XLEN-1:2];
            if (!wval[1]) mtvec_mode_reg <= wval[0];
          end
          ADDR_MSCRATCH: mscratch_reg <= wval;
          ADDR_MEPC:     mepc_reg     <= wval[XLEN-1:2];
          ADDR_MCAUSE:   mcause_reg   <= wval;
          ADDR_MTVAL:    mtval_reg    <= wval;
          default: ;
        endcase
      end
      if (trap) begin
        mepc_reg         <= bus.pc_i[XLEN-1:2];
        mcause_reg       <= trap_cause;
        mtval_reg        <= take_exc ? bus.exp_tval_i : '0;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        redirect_pc_reg  <= trap_target;
      end else if (take_mret) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
        redirect_pc_reg  <= {mepc_reg, 2'b00};
      end
    end
  end

`ifdef CSR_COUNTER_EN
  // Any write to either half suppresses that counter's increment for the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_reg   <= '0;
      minstret_reg <= '0;
    end else begin
      if (csr_we && bus.csr_addr_i == ADDR_MCYCLEH)
        mcycle_reg <= {32'(wval), mcycle_reg[31:0]};
      else if (csr_we && bus.csr_addr_i == ADDR_MCYCLE)
        mcycle_reg <= (XLEN == 32) ? {mcycle_reg[63:32], 32'(wval)} : 64'(wval);
      else
        mcycle_reg <= mcycle_reg + 64'd1;

      if (csr_we && bus.csr_addr_i == ADDR_MINSTRETH)
        minstret_reg <= {32'(wval), minstret_reg[31:0]};
      else if (csr_we && bus.csr_addr_i == ADDR_MINSTRET)
        minstret_reg <= (XLEN == 32) ? {minstret_reg[63:32], 32'(wval)} : 64'(wval);
      else if (bus.instr_retire_i)
        minstret_reg <= minstret_reg + 64'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^bus.pc_i[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{bus.pc_i[1:0], bus.instr_retire_i};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trap || take_mret) state_next = REDIR;
      REDIR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    if (state_reg == REDIR) begin
      bus.redirect_o    = 1'b1;
      bus.redirect_pc_o = redirect_pc_reg;
    end
  end

endmodule
